// File: rtl/trace_pkg.sv
// Shared types and entry layout for the retire-trace monitor.
// Entry layout, LSB first: pc, instr, alu_out, reg_we.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int INSTR_W = 32;

    function automatic int entry_w(input int xlen);
        return 2 * xlen + 33;
    endfunction

    function automatic int off_instr(input int xlen);
        return xlen;
    endfunction

    function automatic int off_alu(input int xlen);
        return xlen + INSTR_W;
    endfunction

    function automatic int off_we(input int xlen);
        return 2 * xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace store: DEPTH x WIDTH simple dual-port RAM, registered read (1 cycle), read-before-write.
// No backpressure: every write and read request is accepted in its cycle.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 97,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_vld,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_vld,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    // No reset so the array and output register can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_vld) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_vld) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/trace_monitor.sv
// Retire trace capture (ring / one-shot PC trigger) with self-loop halt detect; readout latency 1 cycle.
// No backpressure: retires are sampled every cycle, reads are always accepted.
module trace_monitor
    import trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int HALT_CNT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     retire_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [31:0]              instr_i,
    input  logic [XLEN-1:0]          alu_out_i,
    input  logic                     reg_we_i,
    input  logic                     arm_i,
    input  logic                     mode_i,
    input  logic [XLEN-1:0]          trig_pc_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic                     rd_valid_o,
    output logic [XLEN-1:0]          rd_pc_o,
    output logic [XLEN-1:0]          rd_alu_o,
    output logic [31:0]              rd_instr_o,
    output logic                     rd_we_o,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     halted_o,
    output logic [31:0]              cycles_o
);

    localparam int AW        = $clog2(DEPTH);
    localparam int RW        = $clog2(HALT_CNT + 1);
    localparam int ENTRY_W   = entry_w(XLEN);
    localparam int OFF_INSTR = off_instr(XLEN);
    localparam int OFF_ALU   = off_alu(XLEN);
    localparam int OFF_WE    = off_we(XLEN);

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_wr_ptr, r_post_cnt, w_post_val, w_rd_idx;
    logic [AW:0]        r_count;
    logic               r_mode, r_last_vld, r_halted, r_rd_vld, r_rd_hit;
    logic [XLEN-1:0]    r_trig_pc, r_last_pc;
    logic [RW-1:0]      r_run, w_run_nxt;
    logic [31:0]        r_cycles;
    logic               w_trig, w_wr_vld, w_post_ld, w_post_dec;
    logic [ENTRY_W-1:0] w_wr_dat, w_rd_dat;

    assign w_trig = retire_i && (pc_i == r_trig_pc);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_vld    = 1'b0;
        w_post_ld   = 1'b0;
        w_post_val  = '0;
        w_post_dec  = 1'b0;
        if (arm_i) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (!r_mode) begin
                        w_wr_vld = retire_i;
                        if (w_trig) begin
                            if (POST_TRIG == 0) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_post_ld   = 1'b1;
                                w_post_val  = AW'(POST_TRIG);
                                w_state_nxt = ST_POST;
                            end
                        end
                    end else if (w_trig) begin
                        w_wr_vld    = 1'b1;
                        w_post_ld   = 1'b1;
                        w_post_val  = AW'(DEPTH - 1);
                        w_state_nxt = ST_POST;
                    end
                end
                ST_POST: begin
                    if (retire_i) begin
                        w_wr_vld   = 1'b1;
                        w_post_dec = 1'b1;
                        if (r_post_cnt == AW'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= 1'b0;
            r_trig_pc  <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
        end else if (arm_i) begin
            r_mode     <= mode_i;
            r_trig_pc  <= trig_pc_i;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
        end else begin
            if (w_wr_vld) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_count != (AW+1)'(DEPTH)) begin
                    r_count <= r_count + (AW+1)'(1);
                end
            end
            if (w_post_ld) begin
                r_post_cnt <= w_post_val;
            end else if (w_post_dec) begin
                r_post_cnt <= r_post_cnt - AW'(1);
            end
        end
    end

    // Run length saturates at HALT_CNT so a long spin cannot wrap the counter.
    assign w_run_nxt = (r_last_vld && pc_i == r_last_pc)
                     ? ((r_run == RW'(HALT_CNT)) ? r_run : r_run + RW'(1))
                     : RW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run      <= '0;
            r_last_pc  <= '0;
            r_last_vld <= 1'b0;
            r_halted   <= 1'b0;
        end else if (arm_i) begin
            r_run      <= '0;
            r_last_vld <= 1'b0;
            r_halted   <= 1'b0;
        end else if (retire_i) begin
            r_run      <= w_run_nxt;
            r_last_pc  <= pc_i;
            r_last_vld <= 1'b1;
            if (w_run_nxt == RW'(HALT_CNT)) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycles <= '0;
            r_rd_vld <= 1'b0;
            r_rd_hit <= 1'b0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            r_rd_vld <= rd_en_i;
            r_rd_hit <= rd_en_i && ({1'b0, rd_addr_i} < r_count);
        end
    end

    // Index 0 is the oldest entry; at full count the low bits of count are zero.
    assign w_rd_idx = r_wr_ptr - r_count[AW-1:0] + rd_addr_i;
    assign w_wr_dat = {reg_we_i, alu_out_i, instr_i, pc_i};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_vld  (w_wr_vld),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (w_wr_dat),
        .i_rd_vld  (rd_en_i),
        .i_rd_addr (w_rd_idx),
        .o_rd_dat  (w_rd_dat)
    );

    assign rd_valid_o = r_rd_vld;
    assign rd_pc_o    = r_rd_hit ? w_rd_dat[XLEN-1:0]            : '0;
    assign rd_instr_o = r_rd_hit ? w_rd_dat[OFF_INSTR +: INSTR_W] : '0;
    assign rd_alu_o   = r_rd_hit ? w_rd_dat[OFF_ALU +: XLEN]      : '0;
    assign rd_we_o    = r_rd_hit && w_rd_dat[OFF_WE];
    assign state_o    = r_state;
    assign count_o    = r_count;
    assign halted_o   = r_halted;
    assign cycles_o   = r_cycles;

endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor: reads push expected entries to a scoreboard popped by a monitor.
module tb_trace_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_i, reg_we_i, arm_i, mode_i, rd_en_i;
    logic [31:0] pc_i, instr_i, alu_out_i, trig_pc_i;
    logic [3:0]  rd_addr_i;
    logic        rd_valid_o, rd_we_o, halted_o;
    logic [31:0] rd_pc_o, rd_alu_o, rd_instr_o, cycles_o;
    logic [1:0]  state_o;
    logic [4:0]  count_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic        we;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;

    trace_monitor #(.XLEN(32), .DEPTH(16), .POST_TRIG(8), .HALT_CNT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .retire_i   (retire_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .alu_out_i  (alu_out_i),
        .reg_we_i   (reg_we_i),
        .arm_i      (arm_i),
        .mode_i     (mode_i),
        .trig_pc_i  (trig_pc_i),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_valid_o (rd_valid_o),
        .rd_pc_o    (rd_pc_o),
        .rd_alu_o   (rd_alu_o),
        .rd_instr_o (rd_instr_o),
        .rd_we_o    (rd_we_o),
        .state_o    (state_o),
        .count_o    (count_o),
        .halted_o   (halted_o),
        .cycles_o   (cycles_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return {pc[24:0], 7'h13};
    endfunction

    function automatic logic [31:0] f_alu(input logic [31:0] pc);
        return ~pc;
    endfunction

    function automatic logic f_we(input logic [31:0] pc);
        return pc[2];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_i  = 1'b1;
        pc_i      = pc;
        instr_i   = f_instr(pc);
        alu_out_i = f_alu(pc);
        reg_we_i  = f_we(pc);
        tick();
        retire_i  = 1'b0;
    endtask

    task automatic arm(input logic mode, input logic [31:0] trig);
        arm_i     = 1'b1;
        mode_i    = mode;
        trig_pc_i = trig;
        tick();
        arm_i     = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [31:0] pc, input bit zero);
        exp_t e;
        if (zero) e = '{32'h0, 32'h0, 32'h0, 1'b0};
        else      e = '{pc, f_instr(pc), f_alu(pc), f_we(pc)};
        sb_q.push_back(e);
        rd_en_i   = 1'b1;
        rd_addr_i = addr[3:0];
        tick();
        rd_en_i   = 1'b0;
        tick();
    endtask

    // Monitor: every valid readout must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && rd_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: rd_valid_o=1 with no read pending");
            end else begin
                m_e = sb_q.pop_front();
                chk("rd_pc",    rd_pc_o,    m_e.pc);
                chk("rd_instr", rd_instr_o, m_e.instr);
                chk("rd_alu",   rd_alu_o,   m_e.alu);
                chk("rd_we",    rd_we_o,    m_e.we);
            end
        end
    end

    initial begin
        reset = 1'b0; retire_i = 1'b0; pc_i = '0; instr_i = '0; alu_out_i = '0;
        reg_we_i = 1'b0; arm_i = 1'b0; mode_i = 1'b0; trig_pc_i = '0;
        rd_en_i = 1'b0; rd_addr_i = '0;
        tick(); tick();
        chk("rst_state",  state_o,    0);
        chk("rst_count",  count_o,    0);
        chk("rst_halted", halted_o,   0);
        chk("rst_cycles", cycles_o,   0);
        chk("rst_rdvld",  rd_valid_o, 0);
        chk("rst_rdpc",   rd_pc_o,    0);
        reset = 1'b1;

        // Idle: counter runs, retires are ignored, reads beyond count return zeros.
        repeat (100) tick();
        chk("idle_cycles", cycles_o, 100);
        chk("idle_count",  count_o,  0);
        retire(32'h40);
        chk("idle_nowrite", count_o, 0);
        chk("idle_state",   state_o, 0);
        do_read(3, 32'h0, 1'b1);

        // Ring mode, trigger at 0x40.
        arm(1'b0, 32'h40);
        chk("ring_armed", state_o, 1);
        chk("ring_cnt0",  count_o, 0);
        for (int i = 0; i < 32; i++) begin
            retire(32'(i * 4));
            if (i == 16) chk("ring_post", state_o, 2);
            if (i == 23) chk("ring_post_last", state_o, 2);
            if (i == 24) begin
                chk("ring_done",  state_o, 3);
                chk("ring_count", count_o, 16);
            end
        end
        chk("ring_hold_cnt", count_o, 16);
        chk("ring_nohalt",   halted_o, 0);
        do_read(0,  32'h24, 1'b0);
        do_read(7,  32'h40, 1'b0);
        do_read(8,  32'h44, 1'b0);
        do_read(15, 32'h60, 1'b0);

        // One-shot mode, trigger at 0x10.
        arm(1'b1, 32'h10);
        for (int i = 0; i < 32; i++) begin
            retire(32'(i * 4));
            if (i == 3)  chk("os_prefill", count_o, 0);
            if (i == 4)  chk("os_post",    state_o, 2);
            if (i == 19) begin
                chk("os_done",  state_o, 3);
                chk("os_count", count_o, 16);
            end
        end
        do_read(0,  32'h10, 1'b0);
        do_read(5,  32'h24, 1'b0);
        do_read(15, 32'h4C, 1'b0);

        // Arm coincident with a retire at the trigger PC.
        arm_i = 1'b1; mode_i = 1'b0; trig_pc_i = 32'h40;
        retire(32'h40);
        arm_i = 1'b0;
        chk("coin_state", state_o, 1);
        chk("coin_count", count_o, 0);
        retire(32'h40);
        chk("coin_trig_state", state_o, 2);
        chk("coin_trig_count", count_o, 1);
        do_read(0, 32'h40, 1'b0);
        do_read(1, 32'h0,  1'b1);

        // Self-loop halt detection.
        arm(1'b1, 32'hFFFF_FFF0);
        retire(32'h08);
        retire(32'h0C);
        retire(32'h0C);
        retire(32'h0C);
        chk("halt_run3", halted_o, 0);
        retire(32'h0C);
        chk("halt_run4", halted_o, 1);
        retire(32'h10);
        tick();
        chk("halt_sticky", halted_o, 1);
        arm(1'b1, 32'hFFFF_FFF0);
        chk("halt_clear", halted_o, 0);

        // Reset mid-capture, then a fresh ring capture.
        arm(1'b0, 32'h08);
        for (int i = 0; i < 4; i++) retire(32'(i * 4));
        chk("mid_post",  state_o, 2);
        chk("mid_count", count_o, 4);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state",  state_o,  0);
        chk("mid_rst_count",  count_o,  0);
        chk("mid_rst_cycles", cycles_o, 0);
        tick();
        reset = 1'b1;
        arm(1'b0, 32'h10);
        for (int i = 0; i < 13; i++) begin
            retire(32'(i * 4));
            if (i == 11) chk("re_post", state_o, 2);
        end
        chk("re_done",  state_o, 3);
        chk("re_count", count_o, 13);
        do_read(0,  32'h00, 1'b0);
        do_read(12, 32'h30, 1'b0);
        do_read(13, 32'h0,  1'b1);

        tick();
        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
